// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared FSM/grant types and XADC DRP addresses for the DRP scheduler
package adc_sched_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDY, DONE} state_t;
   typedef enum logic {GNT_CPU, GNT_SAMP} grant_t;
   localparam logic [6:0] ADDR_VAUX15  = 7'h1F;
   localparam logic [6:0] ADDR_CONFIG0 = 7'h40;
   localparam logic [6:0] ADDR_CONFIG1 = 7'h41;
endpackage

// File: rtl/adc_sample_timer.sv
// adc_sample_timer: free-running SAMPLE_DIV divider, 1-cycle tick at terminal count
module adc_sample_timer #(
   parameter int unsigned SAMPLE_DIV = 100_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int W = $clog2(SAMPLE_DIV);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(SAMPLE_DIV - 1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/adc_drp_scheduler.sv
// adc_drp_scheduler: shares the XADC DRP between a periodic VAUX15 sampler and CPU MMIO accesses.
// Define ADC_AVG_EN to average 2**AVG_LOG2 good conversions per sample update.
module adc_drp_scheduler
   import adc_sched_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 100_000,
   parameter logic [6:0]  CHAN_ADDR  = ADDR_VAUX15,
   parameter int unsigned TIMEOUT    = 255
`ifdef ADC_AVG_EN
   , parameter int unsigned AVG_LOG2 = 4
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [6:0]  cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   output logic        cpu_err,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [6:0]  drp_daddr,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic [11:0] sample,
   output logic        sample_valid,
   output logic        sample_overrun,
   output logic        busy
);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   state_t state, nstate;
   grant_t gnt, last_grant, pick;
   logic tick, samp_pend, take, sgrant, we_q, err_q, good;
   logic [6:0] addr_q;
   logic [15:0] wdata_q, data_q;
   logic [7:0] wcnt;
   adc_sample_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (.clk(clk), .reset(reset), .tick(tick));
   assign drp_daddr = addr_q;
   assign drp_di = wdata_q;
   always_comb begin
      pick = (cpu_req && samp_pend) ? (last_grant == GNT_CPU ? GNT_SAMP : GNT_CPU)
                                    : (samp_pend ? GNT_SAMP : GNT_CPU);
      take = state == IDLE && (cpu_req || samp_pend);
      sgrant = take && pick == GNT_SAMP;
      nstate = state;
      case (state)
         IDLE:     if (take) nstate = ISSUE;
         ISSUE:    nstate = WAIT_RDY;
         WAIT_RDY: if (drp_drdy || wcnt == TO_LAST) nstate = DONE;
         default:  nstate = IDLE;
      endcase
      drp_den = state == ISSUE;
      drp_dwe = drp_den && we_q;
      cpu_ack = state == DONE && gnt == GNT_CPU;
      cpu_err = cpu_ack && err_q;
      cpu_rdata = (cpu_ack && !err_q) ? data_q : '0;
      good = state == DONE && gnt == GNT_SAMP && !err_q;
      busy = state != IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nstate;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         gnt <= GNT_CPU;
         last_grant <= GNT_CPU;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         data_q <= '0;
         err_q <= 1'b0;
         wcnt <= '0;
         samp_pend <= 1'b0;
         sample_overrun <= 1'b0;
      end else begin
         if (take) begin
            gnt <= pick;
            we_q <= pick == GNT_CPU && cpu_we;
            addr_q <= pick == GNT_CPU ? cpu_addr : CHAN_ADDR;
            wdata_q <= pick == GNT_CPU ? cpu_wdata : '0;
         end
         // a tick coinciding with the sampler grant re-arms pend without counting as overrun
         samp_pend <= tick || (samp_pend && !sgrant);
         if (tick && samp_pend && !sgrant) sample_overrun <= 1'b1;
         wcnt <= state == WAIT_RDY ? wcnt + 8'd1 : 8'd0;
         if (state == WAIT_RDY) begin
            err_q <= !drp_drdy;
            if (drp_drdy) data_q <= drp_do;
         end
         if (state == DONE) last_grant <= gnt;
      end
`ifdef ADC_AVG_EN
   logic [11+AVG_LOG2:0] acc, acc_n;
   logic [AVG_LOG2-1:0] n;
   assign acc_n = acc + {{AVG_LOG2{1'b0}}, data_q[15:4]};
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         acc <= '0;
         n <= '0;
         sample <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= good && &n;
         if (good) begin
            n <= n + 1'b1;
            acc <= &n ? '0 : acc_n;
            if (&n) sample <= acc_n[11+AVG_LOG2:AVG_LOG2];
         end
      end
`else
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sample <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= good;
         if (good) sample <= data_q[15:4];
      end
`endif
endmodule

// File: tb/tb_adc_drp_scheduler.sv
// tb_adc_drp_scheduler: transaction-timestamp reference model plus directed and random DRP traffic
module tb_adc_drp_scheduler;
   import adc_sched_pkg::*;
   localparam int SD = 16;
   localparam int TO = 8;
`ifdef ADC_AVG_EN
   localparam int AL = 2;
`endif
   logic clk = 1'b0, reset = 1'b0;
   logic cpu_req = 1'b0, cpu_we = 1'b0, drp_drdy = 1'b0;
   logic [6:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0, drp_do = '0;
   logic cpu_ack, cpu_err, drp_den, drp_dwe, sample_valid, sample_overrun, busy;
   logic [15:0] cpu_rdata, drp_di;
   logic [6:0] drp_daddr;
   logic [11:0] sample;
   adc_drp_scheduler #(.SAMPLE_DIV(SD), .CHAN_ADDR(ADDR_VAUX15), .TIMEOUT(TO)
`ifdef ADC_AVG_EN
      , .AVG_LOG2(AL)
`endif
   ) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
      .drp_do(drp_do), .drp_drdy(drp_drdy), .sample(sample), .sample_valid(sample_valid),
      .sample_overrun(sample_overrun), .busy(busy)
   );
   always #5 clk = ~clk;
   int checks = 0, failures = 0, p = 0;
   // model: one in-flight access described by its grant fields and cycle timestamps
   bit act, gs, t_we, m_err, pend, ovr, last_s;
   logic [6:0] t_addr;
   logic [15:0] t_wdata, data_m;
   int den_c, done_c, d, sv_c, acc_m, n_m;
   logic [11:0] samp_m;
   // stimulus controls
   int dmode;
   bit do_fixed, cpu_auto, cpu_out, spur_en;
   logic [15:0] do_seq [4];
   int do_idx;
   // DUT observations for literal checks
   logic [6:0] den_q [$];
   int sv_q [$];
   int ack_cnt, last_ack_p, last_den_p;
   logic last_dwe, ack_err;
   logic [15:0] last_di, ack_rdata;
   logic [6:0] last_daddr;
   logic [11:0] sv_sample;
   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, p);
      end
   endtask
   task automatic model_init();
      p = 0; act = 0; gs = 0; pend = 0; ovr = 0; last_s = 0; m_err = 0;
      samp_m = '0; sv_c = -1; den_c = -10; done_c = -10; acc_m = 0; n_m = 0; do_idx = 0;
   endtask
   task automatic conv(input logic [11:0] c);
`ifdef ADC_AVG_EN
      acc_m += int'(c);
      n_m++;
      if (n_m == (1 << AL)) begin
         samp_m = 12'(acc_m >> AL);
         sv_c = p + 1;
         acc_m = 0;
         n_m = 0;
      end
`else
      samp_m = c;
      sv_c = p + 1;
`endif
   endtask
   task automatic step();
      bit e_den, e_ack, tick, sg, ok;
      e_den = act && p == den_c;
      e_ack = act && p == done_c && !gs;
      chk("busy", busy, act && p >= den_c);
      chk("den", drp_den, e_den);
      if (e_den) begin
         chk("dwe", drp_dwe, t_we);
         chk("daddr", drp_daddr, t_addr);
         if (t_we) chk("di", drp_di, t_wdata);
      end
      chk("ack", cpu_ack, e_ack);
      chk("err", cpu_err, e_ack && m_err);
      chk("rdata", cpu_rdata, (e_ack && !m_err) ? data_m : 16'h0);
      chk("svalid", sample_valid, p == sv_c);
      chk("sample", sample, samp_m);
      chk("overrun", sample_overrun, ovr);
      if (drp_den) begin
         den_q.push_back(drp_daddr);
         last_daddr = drp_daddr; last_dwe = drp_dwe; last_di = drp_di; last_den_p = p;
      end
      if (cpu_ack) begin
         ack_cnt++; last_ack_p = p; ack_err = cpu_err; ack_rdata = cpu_rdata;
      end
      if (sample_valid) begin
         sv_q.push_back(p);
         sv_sample = sample;
      end
      drp_drdy = act && d >= 1 && p == den_c + d;
      if (!act && spur_en && $urandom_range(7) == 0) drp_drdy = 1'b1;
      drp_do = (drp_drdy && act) ? data_m : 16'($urandom);
      if (cpu_auto) begin
         if (cpu_out && e_ack) begin
            cpu_req = 1'b0; cpu_out = 0;
         end else if (cpu_out && act && !gs && p >= den_c && $urandom_range(3) == 0) cpu_req = 1'b0;
         else if (!cpu_out && !e_ack && $urandom_range(3) == 0) begin
            cpu_req = 1'b1; cpu_out = 1;
            cpu_we = 1'($urandom); cpu_addr = 7'($urandom); cpu_wdata = 16'($urandom);
         end
      end
      tick = p % SD == SD - 1;
      sg = 0;
      if (act && p == done_c) begin
         last_s = gs;
         if (gs && !m_err) conv(data_m[15:4]);
         act = 0;
      end else if (!act && (cpu_req || pend)) begin
         gs = (cpu_req && pend) ? !last_s : pend;
         sg = gs;
         act = 1;
         den_c = p + 1;
         d = dmode >= 0 ? dmode : ($urandom_range(3) == 0 ? 0 : int'($urandom_range(12, 1)));
         ok = d >= 1 && d <= TO;
         m_err = !ok;
         done_c = den_c + 1 + (ok ? d : TO);
         t_we = gs ? 1'b0 : cpu_we;
         t_addr = gs ? ADDR_VAUX15 : cpu_addr;
         t_wdata = gs ? 16'h0 : cpu_wdata;
         if (gs && do_fixed) begin
            data_m = do_seq[do_idx];
            do_idx = (do_idx + 1) % 4;
         end else data_m = 16'($urandom);
      end
      if (tick && pend && !sg) ovr = 1;
      pend = tick || (pend && !sg);
   endtask
   task automatic run(input int n);
      repeat (n) begin
         step();
         p++;
         @(negedge clk);
      end
   endtask
   task automatic cpu_access(input logic we, input logic [6:0] a, input logic [15:0] wd);
      int a0, n;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      a0 = ack_cnt;
      n = 0;
      while (ack_cnt == a0 && n < 200) begin
         step();
         if (ack_cnt != a0) cpu_req = 1'b0;
         p++;
         @(negedge clk);
         n++;
      end
      cpu_req = 1'b0;
      chk("ack_seen", ack_cnt - a0, 1);
   endtask
   task automatic reset_chk();
      chk("rst_busy", busy, 0);
      chk("rst_den", drp_den, 0);
      chk("rst_dwe", drp_dwe, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_err", cpu_err, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_daddr", drp_daddr, 0);
      chk("rst_svalid", sample_valid, 0);
      chk("rst_sample", sample, 0);
      chk("rst_overrun", sample_overrun, 0);
   endtask
   initial begin
      int n1f, dens, acks, tries;
      bit alt_ok, found;
`ifdef ADC_AVG_EN
      do_seq[0] = 16'h1000; do_seq[1] = 16'h1020; do_seq[2] = 16'h1040; do_seq[3] = 16'h1070;
`else
      for (int i = 0; i < 4; i++) do_seq[i] = 16'hABC0;
`endif
      dmode = 2; do_fixed = 1; cpu_auto = 0; cpu_out = 0; spur_en = 0; ack_cnt = 0;
      repeat (3) @(negedge clk);
      reset_chk();
      model_init();
      reset = 1'b1;
      run(72);
`ifdef ADC_AVG_EN
      chk("avg_valid_count", sv_q.size(), 1);
      chk("avg_valid_cycle", sv_q[0], 69);
      chk("avg_sample", sv_sample, 12'h103);
`else
      chk("samp_valid_count", sv_q.size(), 4);
      chk("samp_first_valid", sv_q[0], 21);
      chk("samp_period", sv_q[1] - sv_q[0], 16);
      chk("samp_value", sv_sample, 12'hABC);
`endif
      chk("samp_daddr", den_q[0], 7'h1F);
      chk("samp_dwe", last_dwe, 0);
      do_fixed = 0;
      den_q.delete();
      acks = ack_cnt;
      cpu_access(1'b1, ADDR_CONFIG1, 16'h2100);
      chk("wr_den_count", den_q.size(), 1);
      chk("wr_daddr", last_daddr, 7'h41);
      chk("wr_dwe", last_dwe, 1);
      chk("wr_di", last_di, 16'h2100);
      chk("wr_err", ack_err, 0);
      chk("wr_latency", last_ack_p - last_den_p, 3);
      run(2);
      chk("wr_ack_once", ack_cnt - acks, 1);
      den_q.delete();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ADDR_CONFIG0; cpu_wdata = 16'h0;
      run(60);
      n1f = 0; alt_ok = 1;
      for (int i = 0; i < den_q.size(); i++)
         if (den_q[i] == 7'h1F) begin
            n1f++;
            if (i == 0 || den_q[i-1] != 7'h40) alt_ok = 0;
            if (i + 1 < den_q.size() && den_q[i+1] != 7'h40) alt_ok = 0;
         end
      chk("alt_samp_grants", n1f >= 2, 1);
      chk("alt_order", alt_ok, 1);
      cpu_req = 1'b0;
      run(12);
      dmode = 0;
      cpu_access(1'b0, ADDR_CONFIG0, 16'h0);
      chk("to_err", ack_err, 1);
      chk("to_rdata", ack_rdata, 0);
      chk("to_wait_cycles", last_ack_p - last_den_p, 9);
      chk("overrun_before", sample_overrun, 0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ADDR_CONFIG0;
      run(80);
      chk("overrun_set", sample_overrun, 1);
      cpu_req = 1'b0; dmode = 2;
      run(30);
      chk("overrun_sticky", sample_overrun, 1);
      dmode = -1; cpu_auto = 1; spur_en = 1;
      run(3000);
      cpu_auto = 0;
      found = 0; tries = 0;
      while (!found && tries < 300) begin
         if (act && p > den_c && p < done_c) found = 1;
         else begin
            run(1);
            tries++;
         end
      end
      chk("mid_access_found", found, 1);
      reset = 1'b0;
      #1;
      reset_chk();
      cpu_req = 1'b0; cpu_out = 0; drp_drdy = 1'b0;
      repeat (2) @(negedge clk);
      model_init();
      reset = 1'b1;
      cpu_auto = 1;
      run(1500);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
